// File: rtl/cr_huf_comp_seq_id_alloc.sv
// Sequence-ID allocator for the Huffman compressor: issues IDs in strict ring order,
// drives the seq-ID context array write port and frees IDs on downstream release.
module cr_huf_comp_seq_id_alloc #(
  parameter int SEQID_NUM   = 8,
  parameter int SEQID_WIDTH = 3,
  parameter int CFG_WIDTH   = 16,
  parameter int CRC_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frm_start_vld,
  input  logic [CFG_WIDTH-1:0]   frm_start_cfg,
  output logic                   frm_start_rdy,
  input  logic                   frm_end_vld,
  input  logic [CRC_WIDTH-1:0]   frm_end_raw_crc,
  input  logic                   rel_vld,
  input  logic [SEQID_WIDTH-1:0] rel_seq_id,
  output logic                   wr_vld,
  output logic                   wr_vld_crc,
  output logic [SEQID_WIDTH-1:0] wr_seq_id,
  output logic [CFG_WIDTH-1:0]   wr_cfg,
  output logic [CRC_WIDTH-1:0]   wr_raw_crc,
  output logic [SEQID_WIDTH-1:0] cur_seq_id,
  output logic [SEQID_WIDTH:0]   inflight_cnt,
  output logic                   all_busy,
  output logic                   err_rel_idle,
  output logic                   err_rel_open,
  output logic                   err_end_no_frame
);

  function automatic logic [SEQID_WIDTH:0] popcount(input logic [SEQID_NUM-1:0] v);
    logic [SEQID_WIDTH:0] n;
    n = '0;
    for (int i = 0; i < SEQID_NUM; i++) begin
      n = n + {{SEQID_WIDTH{1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [SEQID_WIDTH-1:0] alloc_ptr_r, open_id_r, wr_seq_id_r;
  logic [SEQID_NUM-1:0]   busy_r;
  logic                   open_r, rdy_r, wr_vld_r, wr_vld_crc_r, all_busy_r;
  logic                   err_rel_idle_r, err_rel_open_r, err_end_r;
  logic [CFG_WIDTH-1:0]   wr_cfg_r;
  logic [CRC_WIDTH-1:0]   wr_raw_crc_r;
  logic [SEQID_WIDTH:0]   cnt_r;

  logic                   accept_s, end_ok_s, rel_busy_s, rel_open_s, rel_ok_s;
  logic                   open_nxt_s, rdy_nxt_s;
  logic [SEQID_WIDTH-1:0] ptr_nxt_s, wr_id_nxt_s;
  logic [SEQID_NUM-1:0]   busy_nxt_s;
  logic [SEQID_WIDTH:0]   cnt_nxt_s;

  // Next-state decode; rdy is precomputed from next state so the port stays registered
  always_comb begin
    accept_s    = frm_start_vld && rdy_r;
    end_ok_s    = frm_end_vld && open_r;
    rel_busy_s  = busy_r[rel_seq_id];
    rel_open_s  = open_r && (open_id_r == rel_seq_id);
    rel_ok_s    = rel_vld && rel_busy_s && !rel_open_s;
    ptr_nxt_s   = accept_s ? (alloc_ptr_r + SEQID_WIDTH'(1)) : alloc_ptr_r;
    open_nxt_s  = accept_s || (open_r && !end_ok_s);
    busy_nxt_s  = busy_r;
    for (int i = 0; i < SEQID_NUM; i++) begin
      busy_nxt_s[i] = (busy_r[i] && !(rel_ok_s && (rel_seq_id == SEQID_WIDTH'(i))))
                    || (accept_s && (alloc_ptr_r == SEQID_WIDTH'(i)));
    end
    rdy_nxt_s   = !open_nxt_s && !busy_nxt_s[ptr_nxt_s];
    cnt_nxt_s   = popcount(busy_nxt_s);
    wr_id_nxt_s = accept_s ? alloc_ptr_r : (end_ok_s ? open_id_r : wr_seq_id_r);
  end

  // Allocator state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r    <= '0;
      open_id_r      <= '0;
      busy_r         <= '0;
      open_r         <= 1'b0;
      rdy_r          <= 1'b0;
      wr_vld_r       <= 1'b0;
      wr_vld_crc_r   <= 1'b0;
      wr_seq_id_r    <= '0;
      wr_cfg_r       <= '0;
      wr_raw_crc_r   <= '0;
      cnt_r          <= '0;
      all_busy_r     <= 1'b0;
      err_rel_idle_r <= 1'b0;
      err_rel_open_r <= 1'b0;
      err_end_r      <= 1'b0;
    end else begin
      alloc_ptr_r    <= ptr_nxt_s;
      open_id_r      <= accept_s ? alloc_ptr_r : open_id_r;
      busy_r         <= busy_nxt_s;
      open_r         <= open_nxt_s;
      rdy_r          <= rdy_nxt_s;
      wr_vld_r       <= accept_s;
      wr_vld_crc_r   <= end_ok_s;
      wr_seq_id_r    <= wr_id_nxt_s;
      wr_cfg_r       <= accept_s ? frm_start_cfg : wr_cfg_r;
      wr_raw_crc_r   <= end_ok_s ? frm_end_raw_crc : wr_raw_crc_r;
      cnt_r          <= cnt_nxt_s;
      all_busy_r     <= (cnt_nxt_s == (SEQID_WIDTH+1)'(SEQID_NUM));
      err_rel_idle_r <= rel_vld && !rel_busy_s;
      err_rel_open_r <= rel_vld && rel_busy_s && rel_open_s;
      err_end_r      <= frm_end_vld && !open_r;
    end
  end

  assign frm_start_rdy    = rdy_r;
  assign wr_vld           = wr_vld_r;
  assign wr_vld_crc       = wr_vld_crc_r;
  assign wr_seq_id        = wr_seq_id_r;
  assign wr_cfg           = wr_cfg_r;
  assign wr_raw_crc       = wr_raw_crc_r;
  assign cur_seq_id       = open_id_r;
  assign inflight_cnt     = cnt_r;
  assign all_busy         = all_busy_r;
  assign err_rel_idle     = err_rel_idle_r;
  assign err_rel_open     = err_rel_open_r;
  assign err_end_no_frame = err_end_r;

endmodule

// File: tb/tb_cr_huf_comp_seq_id_alloc.sv
// Directed bench for the sequence-ID allocator with hand-computed expectations.
module tb_cr_huf_comp_seq_id_alloc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frm_start_vld = 1'b0;
  logic [15:0] frm_start_cfg = 16'h0;
  logic        frm_start_rdy;
  logic        frm_end_vld = 1'b0;
  logic [63:0] frm_end_raw_crc = 64'h0;
  logic        rel_vld = 1'b0;
  logic [2:0]  rel_seq_id = 3'd0;
  logic        wr_vld, wr_vld_crc, all_busy, err_rel_idle, err_rel_open, err_end_no_frame;
  logic [2:0]  wr_seq_id, cur_seq_id;
  logic [15:0] wr_cfg;
  logic [63:0] wr_raw_crc;
  logic [3:0]  inflight_cnt;

  int n_chk = 0;
  int n_fail = 0;

  cr_huf_comp_seq_id_alloc dut (
    .clk(clk), .rst_n(rst_n),
    .frm_start_vld(frm_start_vld), .frm_start_cfg(frm_start_cfg), .frm_start_rdy(frm_start_rdy),
    .frm_end_vld(frm_end_vld), .frm_end_raw_crc(frm_end_raw_crc),
    .rel_vld(rel_vld), .rel_seq_id(rel_seq_id),
    .wr_vld(wr_vld), .wr_vld_crc(wr_vld_crc), .wr_seq_id(wr_seq_id),
    .wr_cfg(wr_cfg), .wr_raw_crc(wr_raw_crc), .cur_seq_id(cur_seq_id),
    .inflight_cnt(inflight_cnt), .all_busy(all_busy),
    .err_rel_idle(err_rel_idle), .err_rel_open(err_rel_open), .err_end_no_frame(err_end_no_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdy"}, 64'(frm_start_rdy), 64'd0);
    chk({tag, ".wr_vld"}, 64'(wr_vld), 64'd0);
    chk({tag, ".wr_vld_crc"}, 64'(wr_vld_crc), 64'd0);
    chk({tag, ".wr_seq_id"}, 64'(wr_seq_id), 64'd0);
    chk({tag, ".wr_cfg"}, 64'(wr_cfg), 64'd0);
    chk({tag, ".wr_raw_crc"}, wr_raw_crc, 64'd0);
    chk({tag, ".cur_seq_id"}, 64'(cur_seq_id), 64'd0);
    chk({tag, ".inflight"}, 64'(inflight_cnt), 64'd0);
    chk({tag, ".all_busy"}, 64'(all_busy), 64'd0);
    chk({tag, ".errs"}, 64'({err_rel_idle, err_rel_open, err_end_no_frame}), 64'd0);
  endtask

  // Accept a frame, then end it on the following cycle
  task automatic frame(input int id, input logic [15:0] cfg, input logic [63:0] crc);
    frm_start_vld = 1'b1; frm_start_cfg = cfg;
    tick();
    frm_start_vld = 1'b0;
    chk($sformatf("start%0d.wr_vld", id), 64'(wr_vld), 64'd1);
    chk($sformatf("start%0d.seq", id), 64'(wr_seq_id), 64'(id));
    chk($sformatf("start%0d.cfg", id), 64'(wr_cfg), 64'(cfg));
    chk($sformatf("start%0d.cur", id), 64'(cur_seq_id), 64'(id));
    frm_end_vld = 1'b1; frm_end_raw_crc = crc;
    tick();
    frm_end_vld = 1'b0;
    chk($sformatf("end%0d.wr_vld_crc", id), 64'(wr_vld_crc), 64'd1);
    chk($sformatf("end%0d.wr_vld", id), 64'(wr_vld), 64'd0);
    chk($sformatf("end%0d.seq", id), 64'(wr_seq_id), 64'(id));
    chk($sformatf("end%0d.crc", id), wr_raw_crc, crc);
  endtask

  task automatic release_id(input logic [2:0] id);
    rel_vld = 1'b1; rel_seq_id = id;
    tick();
    rel_vld = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk("post_reset.rdy_low", 64'(frm_start_rdy), 64'd0);
    tick();
    chk("post_reset.rdy", 64'(frm_start_rdy), 64'd1);

    // Three frames, no stall
    frame(0, 16'h0011, 64'hA0);
    frame(1, 16'h0022, 64'hA1);
    frame(2, 16'h0033, 64'hA2);
    chk("three.inflight", 64'(inflight_cnt), 64'd3);
    chk("three.all_busy", 64'(all_busy), 64'd0);

    // Fill the ring
    for (int id = 3; id < 8; id++) frame(id, 16'(16'h0010 * id), 64'(64'hA0 + id));
    chk("full.inflight", 64'(inflight_cnt), 64'd8);
    chk("full.all_busy", 64'(all_busy), 64'd1);
    chk("full.rdy", 64'(frm_start_rdy), 64'd0);

    release_id(3'd3);
    chk("rel3.rdy_stall", 64'(frm_start_rdy), 64'd0);
    chk("rel3.inflight", 64'(inflight_cnt), 64'd7);
    chk("rel3.all_busy", 64'(all_busy), 64'd0);

    // Release ID 0 with a start already pending
    rel_vld = 1'b1; rel_seq_id = 3'd0; frm_start_vld = 1'b1; frm_start_cfg = 16'h0044;
    tick();
    rel_vld = 1'b0;
    chk("rel0.rdy", 64'(frm_start_rdy), 64'd1);
    chk("rel0.no_wr", 64'(wr_vld), 64'd0);
    chk("rel0.inflight", 64'(inflight_cnt), 64'd6);
    tick();
    frm_start_vld = 1'b0;
    chk("reissue0.wr_vld", 64'(wr_vld), 64'd1);
    chk("reissue0.seq", 64'(wr_seq_id), 64'd0);
    chk("reissue0.cfg", 64'(wr_cfg), 64'h44);
    chk("reissue0.inflight", 64'(inflight_cnt), 64'd7);
    chk("reissue0.rdy", 64'(frm_start_rdy), 64'd0);

    // Release errors
    release_id(3'd5);
    chk("rel5.inflight", 64'(inflight_cnt), 64'd6);
    chk("rel5.no_err", 64'(err_rel_idle), 64'd0);
    release_id(3'd5);
    chk("rel5_idle.err", 64'(err_rel_idle), 64'd1);
    chk("rel5_idle.inflight", 64'(inflight_cnt), 64'd6);
    tick();
    chk("rel5_idle.pulse_end", 64'(err_rel_idle), 64'd0);

    frm_end_vld = 1'b1; frm_end_raw_crc = 64'hB0;
    tick();
    frm_end_vld = 1'b0;
    chk("end0b.wr_vld_crc", 64'(wr_vld_crc), 64'd1);
    chk("end0b.crc", wr_raw_crc, 64'hB0);
    chk("end0b.rdy", 64'(frm_start_rdy), 64'd0);
    release_id(3'd1);
    chk("rel1.inflight", 64'(inflight_cnt), 64'd5);
    chk("rel1.rdy", 64'(frm_start_rdy), 64'd1);
    frm_start_vld = 1'b1; frm_start_cfg = 16'h0055;
    tick();
    frm_start_vld = 1'b0;
    chk("start1b.seq", 64'(wr_seq_id), 64'd1);
    chk("start1b.inflight", 64'(inflight_cnt), 64'd6);
    release_id(3'd1);
    chk("rel_open1.err", 64'(err_rel_open), 64'd1);
    chk("rel_open1.idle_err", 64'(err_rel_idle), 64'd0);
    chk("rel_open1.inflight", 64'(inflight_cnt), 64'd6);
    tick();
    chk("rel_open1.pulse_end", 64'(err_rel_open), 64'd0);

    // frm_end with no open frame
    frm_end_vld = 1'b1; frm_end_raw_crc = 64'hB1;
    tick();
    chk("end1b.wr_vld_crc", 64'(wr_vld_crc), 64'd1);
    chk("end1b.seq", 64'(wr_seq_id), 64'd1);
    frm_end_raw_crc = 64'hDEAD;
    tick();
    frm_end_vld = 1'b0;
    chk("end_idle.err", 64'(err_end_no_frame), 64'd1);
    chk("end_idle.no_crc", 64'(wr_vld_crc), 64'd0);
    chk("end_idle.crc_hold", wr_raw_crc, 64'hB1);

    // frm_end in the same cycle as an accept
    release_id(3'd2);
    chk("rel2.inflight", 64'(inflight_cnt), 64'd5);
    chk("rel2.err_end_cleared", 64'(err_end_no_frame), 64'd0);
    frm_start_vld = 1'b1; frm_start_cfg = 16'h0066; frm_end_vld = 1'b1; frm_end_raw_crc = 64'hEE;
    tick();
    frm_start_vld = 1'b0; frm_end_vld = 1'b0;
    chk("start_end.wr_vld", 64'(wr_vld), 64'd1);
    chk("start_end.seq", 64'(wr_seq_id), 64'd2);
    chk("start_end.err", 64'(err_end_no_frame), 64'd1);
    chk("start_end.no_crc", 64'(wr_vld_crc), 64'd0);
    chk("start_end.inflight", 64'(inflight_cnt), 64'd6);
    tick();
    chk("start_end.still_open", 64'(frm_start_rdy), 64'd0);
    chk("start_end.no_crc_late", 64'(wr_vld_crc), 64'd0);
    frm_end_vld = 1'b1; frm_end_raw_crc = 64'hB2;
    tick();
    frm_end_vld = 1'b0;
    chk("end2.crc", wr_raw_crc, 64'hB2);
    chk("end2.seq", 64'(wr_seq_id), 64'd2);

    // Release of ID 2 alongside accept of ID 4
    frame(3, 16'h0077, 64'hB3);
    chk("frame3.inflight", 64'(inflight_cnt), 64'd7);
    chk("frame3.rdy_stall", 64'(frm_start_rdy), 64'd0);
    release_id(3'd4);
    chk("rel4.rdy", 64'(frm_start_rdy), 64'd1);
    rel_vld = 1'b1; rel_seq_id = 3'd2; frm_start_vld = 1'b1; frm_start_cfg = 16'h0088;
    tick();
    rel_vld = 1'b0; frm_start_vld = 1'b0;
    chk("rel_acc.wr_vld", 64'(wr_vld), 64'd1);
    chk("rel_acc.seq", 64'(wr_seq_id), 64'd4);
    chk("rel_acc.cfg", 64'(wr_cfg), 64'h88);
    chk("rel_acc.inflight", 64'(inflight_cnt), 64'd6);
    chk("rel_acc.errs", 64'({err_rel_idle, err_rel_open}), 64'd0);

    // Build an open frame on ID 6 with five IDs in flight, then reset
    frm_end_vld = 1'b1; frm_end_raw_crc = 64'hB4;
    tick();
    frm_end_vld = 1'b0;
    frame(5, 16'h0099, 64'hB5);
    release_id(3'd6);
    release_id(3'd0);
    release_id(3'd1);
    chk("pre6.inflight", 64'(inflight_cnt), 64'd4);
    frm_start_vld = 1'b1; frm_start_cfg = 16'h00AB;
    tick();
    frm_start_vld = 1'b0;
    chk("open6.seq", 64'(wr_seq_id), 64'd6);
    chk("open6.cur", 64'(cur_seq_id), 64'd6);
    chk("open6.inflight", 64'(inflight_cnt), 64'd5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst.rdy", 64'(frm_start_rdy), 64'd1);
    chk("after_rst.no_crc", 64'(wr_vld_crc), 64'd0);
    frm_start_vld = 1'b1; frm_start_cfg = 16'h00CD;
    tick();
    frm_start_vld = 1'b0;
    chk("after_rst.wr_vld", 64'(wr_vld), 64'd1);
    chk("after_rst.seq", 64'(wr_seq_id), 64'd0);
    chk("after_rst.cfg", 64'(wr_cfg), 64'hCD);
    chk("after_rst.inflight", 64'(inflight_cnt), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("after_rst.idle%0d.no_crc", k), 64'(wr_vld_crc), 64'd0);
    end
    frm_end_vld = 1'b1; frm_end_raw_crc = 64'hC0;
    tick();
    frm_end_vld = 1'b0;
    chk("after_rst.end.seq", 64'(wr_seq_id), 64'd0);
    chk("after_rst.end.crc", wr_raw_crc, 64'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
